// File: rtl/bram_dp_true_be.sv
// -----------------------------------------------------------------------------
// bram_dp_true_be
// True dual-port block RAM on a single clock. Each port has per-byte write
// enables. The read-during-write behaviour is selectable, there are one or two
// output register stages, and an optional clear engine zeroes the array after
// every reset. Same-address collisions are reported on coll_o.
//
// Parameters
//   RAM_WIDTH      data word width (a multiple of BYTE_WIDTH)
//   BYTE_WIDTH     width of one write-enable lane
//   RAM_ADDR_BITS  address width; DEPTH = 2**RAM_ADDR_BITS
//   RD_MODE        0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//   OUT_REG        0 one output stage, 1 two output stages
//   INIT_CLEAR     1 zero the array after reset, 0 leave contents untouched
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 synchronous active-high reset
//   addr_a_i / addr_b_i   port addresses
//   data_a_i / data_b_i   write data
//   we_a_i / we_b_i       byte write enables, one bit per lane
//   en_a_i / en_b_i       port access enables
//   data_a_o / data_b_o   registered read data
//   valid_a_o / valid_b_o high in the cycle that carries a new access result
//   coll_o                same-address collision pulse, aligned with the data
//   init_busy_o           high while the clear engine runs; requests ignored
// -----------------------------------------------------------------------------
module bram_dp_true_be #(
    parameter int RAM_WIDTH     = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int RAM_ADDR_BITS = 10,
    parameter int RD_MODE       = 0,
    parameter int OUT_REG       = 1,
    parameter int INIT_CLEAR    = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [RAM_ADDR_BITS-1:0]            addr_a_i,
    input  logic [RAM_ADDR_BITS-1:0]            addr_b_i,
    input  logic [RAM_WIDTH-1:0]                data_a_i,
    input  logic [RAM_WIDTH-1:0]                data_b_i,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]     we_a_i,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]     we_b_i,
    input  logic                                en_a_i,
    input  logic                                en_b_i,
    output logic [RAM_WIDTH-1:0]                data_a_o,
    output logic [RAM_WIDTH-1:0]                data_b_o,
    output logic                                valid_a_o,
    output logic                                valid_b_o,
    output logic                                coll_o,
    output logic                                init_busy_o
);

    localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 32'sd2 ** RAM_ADDR_BITS;
    localparam logic [1:0] MODE = RD_MODE[1:0];
    localparam logic [RAM_ADDR_BITS-1:0] CNT_ONE  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [RAM_ADDR_BITS-1:0] CNT_LAST = {RAM_ADDR_BITS{1'b1}};

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 32'sd0) ? ST_INIT : ST_RUN;
    localparam logic   RST_BUSY  = (INIT_CLEAR != 32'sd0);

    // Replace the lanes selected by we with the matching lanes of new_w.
    function automatic logic [RAM_WIDTH-1:0] f_merge(
        input logic [RAM_WIDTH-1:0] old_w,
        input logic [RAM_WIDTH-1:0] new_w,
        input logic [NB-1:0]        we
    );
        logic [RAM_WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < NB; k++) begin
            if (we[k]) begin
                res[k*BYTE_WIDTH +: BYTE_WIDTH] = new_w[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    logic [RAM_WIDTH-1:0]     r_mem [DEPTH];
    state_t                   r_state, w_state_nxt;
    logic [RAM_ADDR_BITS-1:0] r_cnt, w_cnt_nxt;
    logic                     r_busy, w_busy_nxt;

    logic [RAM_WIDTH-1:0] r_d1_a, r_d1_b, w_d1_a_nxt, w_d1_b_nxt;
    logic                 r_v1_a, r_v1_b, r_c1;

    // Requests are ignored during reset and while the clear engine runs.
    logic w_run, w_en_a, w_en_b, w_wr_a, w_wr_b, w_same, w_coll, w_v1_a, w_v1_b;
    logic [RAM_WIDTH-1:0] w_old_a, w_old_b, w_both, w_final_a, w_final_b;

    assign w_run  = (r_state == ST_RUN) & ~rst_i;
    assign w_en_a = en_a_i & w_run;
    assign w_en_b = en_b_i & w_run;
    assign w_wr_a = w_en_a & (|we_a_i);
    assign w_wr_b = w_en_b & (|we_b_i);
    assign w_same = w_en_a & w_en_b & (addr_a_i == addr_b_i);
    assign w_coll = w_same & (w_wr_a | w_wr_b);

    assign w_old_a = r_mem[addr_a_i];
    assign w_old_b = r_mem[addr_b_i];

    // Same-address word: B lanes first, then A lanes on top so A wins overlaps.
    assign w_both    = f_merge(f_merge(w_old_a, data_b_i, we_b_i), data_a_i, we_a_i);
    assign w_final_a = w_same ? w_both : f_merge(w_old_a, data_a_i, we_a_i);
    assign w_final_b = w_same ? w_both : f_merge(w_old_b, data_b_i, we_b_i);

    assign w_v1_a = w_en_a & ~((MODE == 2'd2) & (|we_a_i));
    assign w_v1_b = w_en_b & ~((MODE == 2'd2) & (|we_b_i));

    // Array write port: clear engine in INIT, merged port words in RUN.
    always_ff @(posedge clk_i) begin
        if ((r_state == ST_INIT) && !rst_i) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr_a) begin
                r_mem[addr_a_i] <= w_final_a;
            end
            if (w_wr_b) begin
                r_mem[addr_b_i] <= w_final_b;
            end
        end
    end

    // Clear engine next state: walk every address once, then go to RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Clear engine state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_busy  <= RST_BUSY;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Stage-1 data select; a reading port always sees the pre-write word.
    always_comb begin
        w_d1_a_nxt = r_d1_a;
        w_d1_b_nxt = r_d1_b;
        if (w_en_a) begin
            if (!(|we_a_i)) begin
                w_d1_a_nxt = w_old_a;
            end else begin
                case (MODE)
                    2'd0:    w_d1_a_nxt = w_old_a;
                    2'd1:    w_d1_a_nxt = w_final_a;
                    2'd2:    w_d1_a_nxt = r_d1_a;
                    default: w_d1_a_nxt = w_old_a;
                endcase
            end
        end else begin
            w_d1_a_nxt = r_d1_a;
        end
        if (w_en_b) begin
            if (!(|we_b_i)) begin
                w_d1_b_nxt = w_old_b;
            end else begin
                case (MODE)
                    2'd0:    w_d1_b_nxt = w_old_b;
                    2'd1:    w_d1_b_nxt = w_final_b;
                    2'd2:    w_d1_b_nxt = r_d1_b;
                    default: w_d1_b_nxt = w_old_b;
                endcase
            end
        end else begin
            w_d1_b_nxt = r_d1_b;
        end
    end

    // Stage-1 output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_d1_a <= '0;
            r_d1_b <= '0;
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
            r_c1   <= 1'b0;
        end else begin
            r_d1_a <= w_d1_a_nxt;
            r_d1_b <= w_d1_b_nxt;
            r_v1_a <= w_v1_a;
            r_v1_b <= w_v1_b;
            r_c1   <= w_coll;
        end
    end

    if (OUT_REG != 32'sd0) begin : g_out2
        logic [RAM_WIDTH-1:0] r_d2_a, r_d2_b;
        logic                 r_v2_a, r_v2_b, r_c2;

        // Stage-2 registers copy stage 1 every cycle.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_d2_a <= '0;
                r_d2_b <= '0;
                r_v2_a <= 1'b0;
                r_v2_b <= 1'b0;
                r_c2   <= 1'b0;
            end else begin
                r_d2_a <= r_d1_a;
                r_d2_b <= r_d1_b;
                r_v2_a <= r_v1_a;
                r_v2_b <= r_v1_b;
                r_c2   <= r_c1;
            end
        end

        assign data_a_o  = r_d2_a;
        assign data_b_o  = r_d2_b;
        assign valid_a_o = r_v2_a;
        assign valid_b_o = r_v2_b;
        assign coll_o    = r_c2;
    end else begin : g_out1
        assign data_a_o  = r_d1_a;
        assign data_b_o  = r_d1_b;
        assign valid_a_o = r_v1_a;
        assign valid_b_o = r_v1_b;
        assign coll_o    = r_c1;
    end

    assign init_busy_o = r_busy;

endmodule

// File: tb/tb_bram_dp_true_be.sv
// -----------------------------------------------------------------------------
// tb_bram_dp_true_be
// Three 16-word instances (RD_MODE 0, 1, 2; OUT_REG=1; INIT_CLEAR=1) share
// one stimulus stream. Each request pushes per-instance expectations into a
// queue; a negedge monitor pops and compares them at the cycle where the
// result must appear.
// -----------------------------------------------------------------------------
module tb_bram_dp_true_be;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  we_a, we_b;
    logic        en_a, en_b;

    logic [31:0] d_a [3];
    logic [31:0] d_b [3];
    logic        v_a [3];
    logic        v_b [3];
    logic        coll [3];
    logic        busy [3];

    typedef struct {
        int          cyc;
        int          inst;
        int          port;
        bit          hold;
        logic [31:0] data;
        bit          coll;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last [3][2];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bram_dp_true_be #(
            .RAM_WIDTH(32), .BYTE_WIDTH(8), .RAM_ADDR_BITS(4),
            .RD_MODE(g), .OUT_REG(1), .INIT_CLEAR(1)
        ) u_dut (
            .clk_i(clk), .rst_i(rst),
            .addr_a_i(addr_a), .addr_b_i(addr_b),
            .data_a_i(data_a), .data_b_i(data_b),
            .we_a_i(we_a), .we_b_i(we_b),
            .en_a_i(en_a), .en_b_i(en_b),
            .data_a_o(d_a[g]), .data_b_o(d_b[g]),
            .valid_a_o(v_a[g]), .valid_b_o(v_b[g]),
            .coll_o(coll[g]), .init_busy_o(busy[g])
        );
    end

    // Monitor: match outputs against expectations due in this cycle.
    always @(negedge clk) begin : mon
        logic        vld;
        logic [31:0] dat;
        int          idx;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    vld = (p == 0) ? v_a[i] : v_b[i];
                    dat = (p == 0) ? d_a[i] : d_b[i];
                    idx = -1;
                    for (int j = 0; j < q.size(); j++) begin
                        if (q[j].cyc == cyc && q[j].inst == i && q[j].port == p) begin
                            idx = j;
                            break;
                        end
                    end
                    if (idx >= 0) begin
                        n_vec++;
                        if (vld !== !q[idx].hold || dat !== q[idx].data || coll[i] !== q[idx].coll) begin
                            n_bad++;
                            $display("FAIL mon_i%0d_p%0d cyc %0d: got valid=%0b data=%h coll=%0b, expected valid=%0b data=%h coll=%0b",
                                     i, p, cyc, vld, dat, coll[i], !q[idx].hold, q[idx].data, q[idx].coll);
                        end
                        q.delete(idx);
                    end else if (vld) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_valid_i%0d_p%0d cyc %0d: got valid=1 data=%h, expected valid=0",
                                 i, p, cyc, dat);
                    end
                end
            end
            for (int j = q.size() - 1; j >= 0; j--) begin
                if (q[j].cyc < cyc) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL missing_i%0d_p%0d: expected data=%h at cyc %0d, never compared",
                             q[j].inst, q[j].port, q[j].data, q[j].cyc);
                    q.delete(j);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
        addr_a = 4'h0; addr_b = 4'h0; data_a = 32'h0; data_b = 32'h0;
    endtask

    // x0 = READ_FIRST result, x1 = WRITE_FIRST result; NO_CHANGE writes hold.
    task automatic push(input int i, input int p, input logic [3:0] we,
                        input logic [31:0] x0, input logic [31:0] x1, input bit c);
        exp_t e;
        e.cyc  = cyc + 2;
        e.inst = i;
        e.port = p;
        e.coll = c;
        e.hold = (i == 2) && (we != 4'h0);
        if (e.hold) begin
            e.data = last[i][p];
        end else begin
            e.data = (i == 1) ? x1 : x0;
            last[i][p] = e.data;
        end
        q.push_back(e);
    endtask

    task automatic issue(
        input logic ea, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] wa,
        input logic [31:0] xa0, input logic [31:0] xa1,
        input logic eb, input logic [3:0] ab, input logic [31:0] db, input logic [3:0] wb,
        input logic [31:0] xb0, input logic [31:0] xb1, input bit c);
        en_a = ea; addr_a = aa; data_a = da; we_a = wa;
        en_b = eb; addr_b = ab; data_b = db; we_b = wb;
        for (int i = 0; i < 3; i++) begin
            if (ea) push(i, 0, wa, xa0, xa1, c);
            if (eb) push(i, 1, wb, xb0, xb1, c);
        end
        step();
    endtask

    // Assert reset for n edges; outputs must be zero and busy high after the first.
    task automatic do_reset(input int n);
        rst = 1'b1;
        idle();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            last[i][0] = 32'h0;
            last[i][1] = 32'h0;
        end
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_data_a_i%0d", i), d_a[i], 32'h0);
            check($sformatf("rst_data_b_i%0d", i), d_b[i], 32'h0);
            check($sformatf("rst_flags_i%0d", i),
                  {28'h0, v_a[i], v_b[i], coll[i], busy[i]}, 32'h1);
        end
        repeat (n - 1) step();
    endtask

    // Release reset, try a port A read during INIT, and time the clear.
    task automatic run_clear();
        int n;
        n = 0;
        rst = 1'b0;
        en_a = 1'b1; addr_a = 4'h3;
        do begin
            step();
            n++;
            if (n == 1) idle();
        end while (busy[0] && n < 40);
        check("busy_len", n, 32'd16);
        for (int i = 1; i < 3; i++) check($sformatf("busy_done_i%0d", i), {31'h0, busy[i]}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        do_reset(3);
        run_clear();

        // Cleared array, both ports sweeping.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'(i), 32'h0, 4'h0, 32'h0, 32'h0,
                  1'b1, 4'(15 - i), 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        end

        // Byte enables.
        issue(1'b1, 4'h5, 32'hAABBCCDD, 4'hF, 32'h0, 32'hAABBCCDD,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 4'h5, 32'h11223344, 4'h5, 32'hAABBCCDD, 32'hAA22CC44,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        // Read/read at the same address: no collision.
        issue(1'b1, 4'h5, 32'h0, 4'h0, 32'hAA22CC44, 32'hAA22CC44,
              1'b1, 4'h5, 32'h0, 4'h0, 32'hAA22CC44, 32'hAA22CC44, 1'b0);

        // RD_MODE sweep at address 7.
        issue(1'b1, 4'h7, 32'h01020304, 4'hF, 32'h0, 32'h01020304,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 4'h7, 32'hFFFFFFFF, 4'h3, 32'h01020304, 32'h0102FFFF,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0,
              1'b1, 4'h7, 32'h0, 4'h0, 32'h0102FFFF, 32'h0102FFFF, 1'b0);

        // Write/write collision at address 9; A wins lane 1.
        issue(1'b1, 4'h9, 32'h11111111, 4'h3, 32'h0, 32'h00221111,
              1'b1, 4'h9, 32'h22222222, 4'h6, 32'h0, 32'h00221111, 1'b1);
        issue(1'b1, 4'h9, 32'h0, 4'h0, 32'h00221111, 32'h00221111,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Read/write collision at address 2.
        issue(1'b1, 4'h2, 32'h5, 4'hF, 32'h0, 32'h5,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 4'h2, 32'h9, 4'hF, 32'h5, 32'h9,
              1'b1, 4'h2, 32'h0, 4'h0, 32'h5, 32'h5, 1'b1);
        issue(1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0,
              1'b1, 4'h2, 32'h0, 4'h0, 32'h9, 32'h9, 1'b0);

        // Back-to-back reads interrupted by reset.
        issue(1'b1, 4'h5, 32'h0, 4'h0, 32'hAA22CC44, 32'hAA22CC44,
              1'b1, 4'h7, 32'h0, 4'h0, 32'h0102FFFF, 32'h0102FFFF, 1'b0);
        issue(1'b1, 4'h7, 32'h0, 4'h0, 32'h0102FFFF, 32'h0102FFFF,
              1'b1, 4'h9, 32'h0, 4'h0, 32'h00221111, 32'h00221111, 1'b0);
        issue(1'b1, 4'h2, 32'h0, 4'h0, 32'h9, 32'h9,
              1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        do_reset(1);

        // Reset again when the clear has reached address 6.
        rst = 1'b0;
        repeat (6) step();
        do_reset(1);
        run_clear();

        // Everything written earlier must be zero after the restarted clear.
        issue(1'b1, 4'h5, 32'h0, 4'h0, 32'h0, 32'h0,
              1'b1, 4'h7, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 4'h2, 32'h0, 4'h0, 32'h0, 32'h0,
              1'b1, 4'h9, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        idle();
        repeat (4) step();
        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got cyc %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
